vector_register_file: RTL and testbench

Parametrised vector register file for the SIMD AES datapath, in the decode stage beside the scalar register file. Holds DEPTH registers of LANES lanes × N bits each (default 16 × 128-bit, one AES state per register). Provides two registered read ports and one write port with per-lane write mask and same-cycle write-to-read forwarding. Adds a multi-cycle zeroize sweep that wipes key and state material without a reset.

---
 rtl/vrf_pkg.sv | 39 +++
 rtl/vector_register_file_zeroize_fsm.sv | 78 +++++++
 rtl/vector_register_file.sv | 102 ++++++++++
 tb/tb_vector_register_file.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vrf_pkg.sv
// Shared definitions for the vector register file.
// - vrf_state_t : zeroize sweep states (IDLE, SWEEP, DONE)
// - VRF_N / VRF_LANES / VRF_DEPTH : default geometry (16 x 128-bit registers)
// - lane_merge() : per-lane select of new vs. old data. It is used by both the
//   array write path and the read-forwarding path, so they always agree.
package vrf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } vrf_state_t;

  localparam int VRF_N     = 8;
  localparam int VRF_LANES = 16;
  localparam int VRF_DEPTH = 16;

  // Upper bound on the register width that lane_merge handles. Callers
  // zero-extend their operands to this width and cast the result back, which
  // keeps the helper usable for any parametrisation of the register file.
  localparam int VRF_MAX_W = 1024;

  // Bit b belongs to lane b/lane_bits. A lane takes new_val when its mask
  // bit is set and keeps old_val otherwise.
  function automatic logic [VRF_MAX_W-1:0] lane_merge(
    input logic [VRF_MAX_W-1:0] old_val,
    input logic [VRF_MAX_W-1:0] new_val,
    input logic [VRF_MAX_W-1:0] mask,
    input int                   lane_bits
  );
    logic [VRF_MAX_W-1:0] res;
    res = old_val;
    for (int b = 0; b < VRF_MAX_W; b++) begin
      if (mask[b / lane_bits]) res[b] = new_val[b];
    end
    return res;
  endfunction

endpackage

// File: rtl/vector_register_file_zeroize_fsm.sv
// Zeroize sweep controller for the vector register file.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   clr_req    : start a sweep (honoured only in IDLE)
//   we, wm_any : write enable and "some lane selected"; used to flag drops
//   sweep_we   : array clear strobe for reg[sweep_idx] this cycle
//   sweep_idx  : register being cleared
//   busy       : high for the DEPTH sweep cycles
//   done       : one-cycle pulse in the cycle after the last clear
//   wr_drop    : one-cycle pulse after a write was discarded during a sweep
module vrf_zeroize_fsm
  import vrf_pkg::*;
#(
  parameter int DEPTH = VRF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  input  logic          we,
  input  logic          wm_any,
  output logic          sweep_we,
  output logic [AW-1:0] sweep_idx,
  output logic          busy,
  output logic          done,
  output logic          wr_drop
);

  vrf_state_t    state_reg, state_next;
  logic [AW-1:0] idx_reg, idx_next;
  logic          drop_reg, drop_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      drop_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      drop_reg  <= drop_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    drop_next  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (clr_req) begin
          state_next = SWEEP;
          idx_next   = '0;
        end
      end
      SWEEP: begin
        // The array ignores writes while sweeping; report it one cycle later.
        drop_next = we && wm_any;
        if (idx_reg == AW'(DEPTH - 1)) begin
          state_next = DONE;
          idx_next   = '0;  // explicit wrap so non-power-of-two DEPTH works
        end else begin
          idx_next = idx_reg + AW'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // All outputs decode registered state only: no input-to-output paths.
  assign sweep_we  = (state_reg == SWEEP);
  assign sweep_idx = idx_reg;
  assign busy      = (state_reg == SWEEP);
  assign done      = (state_reg == DONE);
  assign wr_drop   = drop_reg;

endmodule

// File: rtl/vector_register_file.sv
// SIMD vector register file: DEPTH registers of LANES x N bits.
// Ports:
//   clk, rst : clock, asynchronous active-high reset (clears every register)
//   A1, A2   : read addresses; RD1/RD2 are registered (1-cycle latency)
//   A3, WD3  : write address / data; WM3 selects lanes, WE3 enables
//   clr_req  : start a zeroize sweep of all registers
//   busy     : sweep in progress; done : sweep-complete pulse
//   wr_drop  : pulse after a write was discarded because a sweep was running
// A write that hits a read address in the same cycle is forwarded as the
// post-merge value. Register 0 is hard-wired to zero when ZERO_REG = 1.
module vector_register_file
  import vrf_pkg::*;
#(
  parameter int N        = VRF_N,
  parameter int LANES    = VRF_LANES,
  parameter int DEPTH    = VRF_DEPTH,
  parameter int ZERO_REG = 1,
  localparam int W  = LANES * N,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    A1,
  input  logic [AW-1:0]    A2,
  input  logic [AW-1:0]    A3,
  input  logic [W-1:0]     WD3,
  input  logic [LANES-1:0] WM3,
  input  logic             WE3,
  input  logic             clr_req,
  output logic [W-1:0]     RD1,
  output logic [W-1:0]     RD2,
  output logic             busy,
  output logic             done,
  output logic             wr_drop
);

  logic [W-1:0]  mem_reg [DEPTH];
  logic          sweep_we;
  logic [AW-1:0] sweep_idx;
  logic          wr_en;
  logic [W-1:0]  wr_merged;
  logic [AW-1:0] ra [2];

  vrf_zeroize_fsm #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .clr_req   (clr_req),
    .we        (WE3),
    .wm_any    (|WM3),
    .sweep_we  (sweep_we),
    .sweep_idx (sweep_idx),
    .busy      (busy),
    .done      (done),
    .wr_drop   (wr_drop)
  );

  // Writes are accepted outside the sweep and never land in a hard-wired
  // zero register. The same wr_en gates forwarding, so a discarded write is
  // never visible on a read port.
  always_comb begin
    wr_en     = WE3 && !sweep_we && !((ZERO_REG != 0) && (A3 == '0));
    wr_merged = W'(lane_merge(VRF_MAX_W'(mem_reg[A3]), VRF_MAX_W'(WD3),
                              VRF_MAX_W'(WM3), N));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      if (sweep_we)   mem_reg[sweep_idx] <= '0;
      else if (wr_en) mem_reg[A3]        <= wr_merged;
    end
  end

  assign ra[0] = A1;
  assign ra[1] = A2;

  // Both read ports are identical: forward the merged write on an address
  // match, but a zero register always reads 0.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [W-1:0] rd_next;
    logic [W-1:0] rd_reg;

    always_comb begin
      rd_next = mem_reg[ra[gi]];
      if (wr_en && (ra[gi] == A3)) rd_next = wr_merged;
      if ((ZERO_REG != 0) && (ra[gi] == '0)) rd_next = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_reg <= '0;
      else     rd_reg <= rd_next;
    end
  end

  assign RD1 = g_rd[0].rd_reg;
  assign RD2 = g_rd[1].rd_reg;

endmodule

// File: tb/tb_vector_register_file.sv
// Bench for vector_register_file. The driver applies one transaction per
// clock, predicts the response from a lane-array model plus a sweep
// timeline (a sweep accepted in cycle k is busy in k+1..k+DEPTH and done
// in k+DEPTH+1), and queues the prediction. A monitor on the falling edge
// pops each prediction and compares it with the DUT outputs.
module tb_vector_register_file;

  localparam int N     = 8;
  localparam int LANES = 16;
  localparam int DEPTH = 16;
  localparam int W     = N * LANES;
  localparam int AW    = $clog2(DEPTH);

  typedef struct {
    logic [W-1:0] rd1;
    logic [W-1:0] rd2;
    logic         busy;
    logic         done;
    logic         drop;
  } exp_t;

  logic             clk;
  logic             rst;
  logic [AW-1:0]    A1, A2, A3;
  logic [W-1:0]     WD3;
  logic [LANES-1:0] WM3;
  logic             WE3;
  logic             clr_req;
  logic [W-1:0]     RD1, RD2;
  logic             busy, done, wr_drop;

  vector_register_file #(
    .N        (N),
    .LANES    (LANES),
    .DEPTH    (DEPTH),
    .ZERO_REG (1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .A1      (A1),
    .A2      (A2),
    .A3      (A3),
    .WD3     (WD3),
    .WM3     (WM3),
    .WE3     (WE3),
    .clr_req (clr_req),
    .RD1     (RD1),
    .RD2     (RD2),
    .busy    (busy),
    .done    (done),
    .wr_drop (wr_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [N-1:0] mm [DEPTH][LANES];
  int           cyc;
  bit           sw_act;
  int           sw_start;

  exp_t q[$];
  exp_t mon_e;
  int   checks_total  = 0;
  int   checks_passed = 0;
  int   txn           = 0;
  int   busy_cnt      = 0;
  int   done_cnt      = 0;
  int   drop_cnt      = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    checks_total++;
    if (act === expv) checks_passed++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  always @(negedge clk) begin
    if (!rst && q.size() > 0) begin
      mon_e = q.pop_front();
      txn++;
      chk("rd1", RD1, mon_e.rd1);
      chk("rd2", RD2, mon_e.rd2);
      chk("busy", W'(busy), W'(mon_e.busy));
      chk("done", W'(done), W'(mon_e.done));
      chk("wr_drop", W'(wr_drop), W'(mon_e.drop));
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) done_cnt++;
      if (wr_drop === 1'b1) drop_cnt++;
      $display("txn %0d rd1=%h rd2=%h busy=%b done=%b drop=%b",
               txn, RD1, RD2, busy, done, wr_drop);
    end
  end

  function automatic bit model_busy(input int c);
    return sw_act && (c - sw_start) >= 1 && (c - sw_start) <= DEPTH;
  endfunction

  function automatic bit model_done(input int c);
    return sw_act && (c - sw_start) == DEPTH + 1;
  endfunction

  function automatic logic [W-1:0] model_read(input int a, input int a3,
                                              input logic [W-1:0] wd,
                                              input logic [LANES-1:0] wm,
                                              input bit wacc);
    logic [W-1:0] r;
    r = '0;
    if (a == 0) return r;
    for (int l = 0; l < LANES; l++)
      r[l*N +: N] = (wacc && a3 == a && wm[l]) ? wd[l*N +: N] : mm[a][l];
    return r;
  endfunction

  function automatic logic [W-1:0] rand_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Called at posedge+1: apply inputs for this cycle, predict the state
  // after the coming edge, then queue the prediction once the edge passed.
  task automatic step(input int a1, input int a2, input int a3,
                      input logic [W-1:0] wd, input logic [LANES-1:0] wm,
                      input bit we, input bit clr);
    exp_t e;
    int   k;
    bit   busy_now, done_now, wacc;
    A1 = AW'(a1); A2 = AW'(a2); A3 = AW'(a3);
    WD3 = wd; WM3 = wm; WE3 = we; clr_req = clr;
    k        = cyc;
    busy_now = model_busy(k);
    done_now = model_done(k);
    wacc     = we && !busy_now && a3 != 0;
    e.rd1    = model_read(a1, a3, wd, wm, wacc);
    e.rd2    = model_read(a2, a3, wd, wm, wacc);
    e.drop   = busy_now && we && (wm != '0);
    if (wacc)
      for (int l = 0; l < LANES; l++) if (wm[l]) mm[a3][l] = wd[l*N +: N];
    if (busy_now)
      for (int l = 0; l < LANES; l++) mm[k - sw_start - 1][l] = '0;
    if (!busy_now && !done_now && clr) begin
      sw_act   = 1'b1;
      sw_start = k;
    end
    cyc    = k + 1;
    e.busy = model_busy(cyc);
    e.done = model_done(cyc);
    @(posedge clk);
    #1;
    q.push_back(e);
  endtask

  task automatic read_step(input int a1, input int a2);
    step(a1, a2, 0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    exp_t z;
    rst = 1'b1;
    A1 = '0; A2 = '0; A3 = '0; WD3 = '0; WM3 = '0; WE3 = 1'b0; clr_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    for (int r = 0; r < DEPTH; r++)
      for (int l = 0; l < LANES; l++) mm[r][l] = '0;
    cyc    = 0;
    sw_act = 1'b0;
    sw_start = 0;
    rst    = 1'b0;
    z.rd1 = '0; z.rd2 = '0; z.busy = 1'b0; z.done = 1'b0; z.drop = 1'b0;
    q.push_back(z);  // outputs straight out of reset
  endtask

  task automatic fill_all();
    for (int r = 0; r < DEPTH; r++) step(0, 0, r, rand_data(), '1, 1'b1, 1'b0);
  endtask

  logic [W-1:0] pat, aa, x5a, xff;

  initial begin
    for (int l = 0; l < LANES; l++) begin
      pat[l*N +: N] = 8'((15 - l) * 17);  // 0x0011..EEFF
      aa[l*N +: N]  = 8'hAA;
      x5a[l*N +: N] = 8'h5A;
      xff[l*N +: N] = 8'hFF;
    end

    do_reset();
    for (int i = 0; i < DEPTH; i++) read_step(i, DEPTH - 1 - i);

    // Full then masked write to reg 5
    step(0, 0, 5, pat, 16'hFFFF, 1'b1, 1'b0);
    step(0, 0, 5, aa, 16'h000F, 1'b1, 1'b0);
    read_step(5, 5);
    // WE3 with empty mask: no change, no drop
    step(5, 0, 5, xff, 16'h0000, 1'b1, 1'b0);

    // Same-cycle forwarding on both ports
    step(7, 7, 7, x5a, 16'hFFFF, 1'b1, 1'b0);
    // Partial-mask forward
    step(7, 5, 7, aa, 16'hF0F0, 1'b1, 1'b0);

    // Hard-wired zero register
    step(0, 0, 0, xff, 16'hFFFF, 1'b1, 1'b0);
    read_step(0, 0);

    // Sweep with a dropped write and an ignored second request
    fill_all();
    busy_cnt = 0; done_cnt = 0; drop_cnt = 0;
    step(1, 2, 0, '0, '0, 1'b0, 1'b1);
    for (int j = 0; j < DEPTH + 2; j++) begin
      if (j == 4)      step(3, 3, 3, xff, 16'hFFFF, 1'b1, 1'b0);
      else if (j == 8) step(j, 15, 0, '0, '0, 1'b0, 1'b1);
      else             step(j % DEPTH, (j + 3) % DEPTH, 0, '0, '0, 1'b0, 1'b0);
    end
    for (int i = 0; i < DEPTH; i++) read_step(i, i);
    chk("sweep_busy_cycles", W'(busy_cnt), W'(DEPTH));
    chk("sweep_done_pulses", W'(done_cnt), W'(1));
    chk("sweep_drop_pulses", W'(drop_cnt), W'(1));

    // Reset in the middle of a sweep (while index 6 is being cleared)
    fill_all();
    step(0, 0, 0, '0, '0, 1'b0, 1'b1);
    for (int j = 0; j < 6; j++) read_step(9, 10);
    chk("busy_before_rst", W'(busy), W'(1));
    rst = 1'b1;
    #1;
    chk("busy_async_rst", W'(busy), W'(0));
    chk("rd1_async_rst", RD1, '0);
    chk("rd2_async_rst", RD2, '0);
    do_reset();
    for (int i = 0; i < DEPTH; i++) read_step(i, DEPTH - 1 - i);

    // Fresh sweep after reset
    fill_all();
    busy_cnt = 0; done_cnt = 0;
    step(0, 0, 0, '0, '0, 1'b0, 1'b1);
    for (int j = 0; j < DEPTH + 4; j++) read_step(j % DEPTH, 4);
    chk("resweep_busy_cycles", W'(busy_cnt), W'(DEPTH));
    chk("resweep_done_pulses", W'(done_cnt), W'(1));

    // Random traffic, occasional sweeps
    for (int i = 0; i < 300; i++) begin
      logic [LANES-1:0] wm;
      int sel;
      sel = $urandom_range(0, 3);
      wm  = (sel == 0) ? 16'h0000 : (sel == 1) ? 16'hFFFF : LANES'($urandom());
      step($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
           $urandom_range(0, DEPTH - 1), rand_data(), wm,
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 29) == 0));
    end

    @(negedge clk);
    #1;
    chk("queue_drained", W'(q.size()), W'(0));
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
